fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Owns the fetch program counter and decides every cycle which address the fetch stage presents to instruction memory.
- Next-PC sources: sequential (+4), branch/jump redirect, exception vector, eret return (EPC), or hold on stall.
- Checks every next PC for alignment and instruction-memory range; flags fetch address errors (AdEL) to the CP0/exception logic.
- Inserts a one-cycle fetch bubble on trap entry and exit.
- Sits between the stall/hazard unit, the D-stage branch logic and CP0, driving IM and the IF/ID register.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- EXC_VEC, 32'h0000_4180, exception handler entry address.
- IMEM_LO, 32'h0000_3000, lowest legal fetch address.
- IMEM_HI, 32'h0000_6ffc, highest legal fetch address.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on the rising clk edge.
- stall  in  1  hold PC and IF/ID (hazard unit).
- br_taken  in  1  D-stage branch taken this cycle.
- br_target  in  32  branch target.
- jump  in  1  D-stage j/jal/jr this cycle.
- jump_target  in  32  jump target.
- exc_req  in  1  CP0 requests exception entry.
- eret  in  1  eret committing.
- epc  in  32  return address from CP0.
- pc  out  32  current fetch address to IM.
- pc_valid  out  1  fetch slot holds a real instruction (0 = bubble).
- flush_f  out  1  clear IF/ID this cycle.
- adel  out  1  current pc is misaligned or out of range.
- state_o  out  2  FSM state, for debug and verification.

Behaviour:
- Reset (reset==0 at the edge):
  - pc=RESET_PC, state=RUN, pc_valid=1, flush_f=0, adel=0.
  - Reset mid-TRAP or mid-HOLD also returns to RUN.
  - Any concurrent inputs are ignored.
- States: RUN (0), HOLD (1), TRAP (2). Encoding 3 is illegal and maps to RUN.
- Next-PC priority, highest first:
  1. exc_req
  2. eret
  3. stall
  4. br_taken
  5. jump
  6. pc+4
- RUN:
  - exc_req: pc<=EXC_VEC, ->TRAP.
  - else eret: pc<=epc, ->TRAP.
  - else stall: pc holds, ->HOLD.
  - else br_taken: pc<=br_target.
  - else jump: pc<=jump_target.
  - else pc<=pc+4.
  - Redirects take effect in one cycle. There is no bubble, because the delay slot is already fetched.
- HOLD:
  - pc holds while stall==1.
  - When stall drops, apply the same priority as RUN and return to RUN.
  - A branch/jump presented during stall is not latched; the D stage re-presents it after the stall.
  - exc_req or eret during HOLD overrides the stall and goes to TRAP.
- TRAP:
  - Lasts exactly one cycle.
  - flush_f=1 and pc_valid=0 during TRAP.
  - pc holds the vector/EPC.
  - Next cycle: ->RUN, pc<=pc+4 unless exc_req (re-enter TRAP at EXC_VEC) or stall (->HOLD, pc held).
  - eret during TRAP is ignored.
- flush_f is also asserted combinationally in the cycle exc_req or eret is sampled high.
- adel:
  - Registered alongside pc.
  - Set when the new pc[1:0]!=0, or pc<IMEM_LO, or pc>IMEM_HI (unsigned compare).
  - The faulting address is still loaded into pc so CP0 can capture it as BadVAddr.
  - adel stays high while pc holds and clears on the next legal pc.
  - No internal trap is taken; CP0 must raise exc_req.
- Arithmetic: pc+4 is 32-bit and wraps modulo 2^32. 32'hffff_fffc+4 = 0, which sets adel.
- Outputs are registered except flush_f.

Decomposition:
- Shared package (cpu_defs): RESET_PC, EXC_VEC, IMEM_LO, IMEM_HI, and the FSM state encodings.
- Sub-module pc_range_check: combinational, 32-bit address in, adel_next out. It is reusable by the D-stage data address checks.

Test Plan:
- Reset, then 3 free-run cycles -> pc 0x3000, 0x3004, 0x3008, 0x300c; adel=0; pc_valid=1.
- At pc=0x3010, stall for 2 cycles with br_taken=1 (br_target=0x3100) during the stall, then release with br_taken=0 -> pc held at 0x3010 in HOLD, then 0x3014.
- exc_req and br_taken in the same cycle at pc=0x3020 -> flush_f=1 that cycle; pc=0x4180 with state TRAP and pc_valid=0; then 0x4184 in RUN.
- eret with epc=0x3024 -> pc=0x3024, one bubble, then 0x3028.
- jump_target=0x3002, then separately br_target=0x7000 -> adel=1 with pc=0x3002 (respectively 0x7000); adel clears after the following exc_req redirect to 0x4180.
- reset driven low while in TRAP -> next pc=0x3000, state RUN, flush_f=0.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared CPU front-end constants: fetch addresses, legal IM window, fetch FSM states.
package cpu_defs;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] RESET_PC = 32'h0000_3000;
   localparam logic [XLEN-1:0] EXC_VEC  = 32'h0000_4180;
   localparam logic [XLEN-1:0] IMEM_LO  = 32'h0000_3000;
   localparam logic [XLEN-1:0] IMEM_HI  = 32'h0000_6ffc;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_HOLD = 2'd1,
      ST_TRAP = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_pc_range_check.sv
// Flags a word address that is misaligned or outside the legal IM window.
module pc_range_check
   import cpu_defs::*;
(
   input  logic [XLEN-1:0] addr_i,
   output logic            adel_next_o
);

   assign adel_next_o = (addr_i[1:0] != 2'b00) || (addr_i < IMEM_LO) || (addr_i > IMEM_HI);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch PC owner: selects next PC by priority, inserts trap bubbles, flags AdEL.
module fetch_sequencer
   import cpu_defs::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            br_taken,
   input  logic [XLEN-1:0] br_target,
   input  logic            jump,
   input  logic [XLEN-1:0] jump_target,
   input  logic            exc_req,
   input  logic            eret,
   input  logic [XLEN-1:0] epc,
   output logic [XLEN-1:0] pc,
   output logic            pc_valid,
   output logic            flush_f,
   output logic            adel,
   output logic [1:0]      state_o
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pc_plus4;
   logic            adel_q, adel_d;
   logic            pc_valid_q;

   assign pc_plus4 = pc_q + XLEN'(4);

   pc_range_check u_range (
      .addr_i      (pc_d),
      .adel_next_o (adel_d)
   );

   // Next-PC selection; HOLD shares RUN priority since stall outranks redirects.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      case (state_q)
         ST_TRAP: begin
            if (exc_req) begin
               pc_d    = EXC_VEC;
               state_d = ST_TRAP;
            end else if (stall) begin
               state_d = ST_HOLD;
            end else begin
               pc_d    = pc_plus4;
               state_d = ST_RUN;
            end
         end
         default: begin
            if (exc_req) begin
               pc_d    = EXC_VEC;
               state_d = ST_TRAP;
            end else if (eret) begin
               pc_d    = epc;
               state_d = ST_TRAP;
            end else if (stall) begin
               state_d = ST_HOLD;
            end else if (br_taken) begin
               pc_d    = br_target;
               state_d = ST_RUN;
            end else if (jump) begin
               pc_d    = jump_target;
               state_d = ST_RUN;
            end else begin
               pc_d    = pc_plus4;
               state_d = ST_RUN;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_RUN;
         pc_q       <= RESET_PC;
         adel_q     <= 1'b0;
         pc_valid_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         adel_q     <= adel_d;
         pc_valid_q <= (state_d != ST_TRAP);
      end
   end

   // Flush is combinational so IF/ID is cleared in the same cycle the trap is requested.
   assign flush_f  = reset && ((state_q == ST_TRAP) || exc_req || eret);
   assign pc       = pc_q;
   assign pc_valid = pc_valid_q;
   assign adel     = adel_q;
   assign state_o  = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a queue-based expected-result scoreboard.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall, br_taken, jump, exc_req, eret;
   logic [31:0] br_target, jump_target, epc;
   logic [31:0] pc;
   logic        pc_valid, flush_f, adel;
   logic [1:0]  state_o;

   localparam logic [1:0] RUN  = 2'd0;
   localparam logic [1:0] HOLD = 2'd1;
   localparam logic [1:0] TRAP = 2'd2;

   typedef struct {
      string       tag;
      logic [31:0] pc;
      logic        valid;
      logic        adel;
      logic [1:0]  st;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   fetch_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .br_taken    (br_taken),
      .br_target   (br_target),
      .jump        (jump),
      .jump_target (jump_target),
      .exc_req     (exc_req),
      .eret        (eret),
      .epc         (epc),
      .pc          (pc),
      .pc_valid    (pc_valid),
      .flush_f     (flush_f),
      .adel        (adel),
      .state_o     (state_o)
   );

   always #5 clk = ~clk;

   task automatic idle();
      stall = 0; br_taken = 0; jump = 0; exc_req = 0; eret = 0;
      br_target = '0; jump_target = '0; epc = '0;
   endtask

   // Push expectation, advance one edge, then pop and compare registered outputs.
   task automatic cyc(input string tag, input logic [31:0] e_pc, input logic e_v,
                      input logic e_a, input logic [1:0] e_st);
      exp_t e;
      sb.push_back('{tag, e_pc, e_v, e_a, e_st});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      assert (pc === e.pc) else begin
         failures++;
         $error("FAIL %s pc got=%h exp=%h", e.tag, pc, e.pc);
      end
      checks++;
      assert (pc_valid === e.valid) else begin
         failures++;
         $error("FAIL %s pc_valid got=%b exp=%b", e.tag, pc_valid, e.valid);
      end
      checks++;
      assert (adel === e.adel) else begin
         failures++;
         $error("FAIL %s adel got=%b exp=%b", e.tag, adel, e.adel);
      end
      checks++;
      assert (state_o === e.st) else begin
         failures++;
         $error("FAIL %s state got=%0d exp=%0d", e.tag, state_o, e.st);
      end
   endtask

   task automatic chk_flush(input string tag, input logic e_f);
      #1;
      checks++;
      assert (flush_f === e_f) else begin
         failures++;
         $error("FAIL %s flush_f got=%b exp=%b", tag, flush_f, e_f);
      end
   endtask

   initial begin
      idle();
      reset = 0;
      exc_req = 1; br_taken = 1; br_target = 32'h0000_3100;
      @(posedge clk);
      cyc("reset", 32'h3000, 1, 0, RUN);
      chk_flush("reset_flush", 0);

      reset = 1; idle();
      cyc("run1", 32'h3004, 1, 0, RUN);
      cyc("run2", 32'h3008, 1, 0, RUN);
      cyc("run3", 32'h300c, 1, 0, RUN);
      cyc("run4", 32'h3010, 1, 0, RUN);

      stall = 1; br_taken = 1; br_target = 32'h3100;
      cyc("hold1", 32'h3010, 1, 0, HOLD);
      cyc("hold2", 32'h3010, 1, 0, HOLD);
      idle();
      cyc("release", 32'h3014, 1, 0, RUN);
      cyc("run5", 32'h3018, 1, 0, RUN);
      cyc("run6", 32'h301c, 1, 0, RUN);
      cyc("run7", 32'h3020, 1, 0, RUN);

      exc_req = 1; br_taken = 1; br_target = 32'h3100;
      chk_flush("flush_exc", 1);
      cyc("exc", 32'h4180, 0, 0, TRAP);
      idle();
      chk_flush("flush_trap", 1);
      cyc("post_exc", 32'h4184, 1, 0, RUN);
      chk_flush("flush_idle", 0);

      eret = 1; epc = 32'h3024;
      chk_flush("flush_eret", 1);
      cyc("eret", 32'h3024, 0, 0, TRAP);
      idle();
      cyc("post_eret", 32'h3028, 1, 0, RUN);

      jump = 1; jump_target = 32'h3002;
      cyc("jmp_misalign", 32'h3002, 1, 1, RUN);
      idle(); stall = 1;
      cyc("adel_hold", 32'h3002, 1, 1, HOLD);
      idle(); exc_req = 1;
      cyc("exc_clr", 32'h4180, 0, 0, TRAP);
      cyc("trap_reexc", 32'h4180, 0, 0, TRAP);
      idle(); eret = 1; epc = 32'h3500;
      cyc("trap_eret_ign", 32'h4184, 1, 0, RUN);

      idle(); br_taken = 1; br_target = 32'h7000;
      cyc("br_hi", 32'h7000, 1, 1, RUN);
      idle(); exc_req = 1;
      cyc("exc_clr2", 32'h4180, 0, 0, TRAP);
      idle(); stall = 1;
      cyc("trap_stall", 32'h4180, 1, 0, HOLD);

      idle(); br_taken = 1; br_target = 32'h6ffc;
      cyc("br_top", 32'h6ffc, 1, 0, RUN);
      idle();
      cyc("top_plus4", 32'h7000, 1, 1, RUN);
      br_taken = 1; br_target = 32'hffff_fffc;
      cyc("br_max", 32'hffff_fffc, 1, 1, RUN);
      idle();
      cyc("wrap", 32'h0000_0000, 1, 1, RUN);
      br_taken = 1; br_target = 32'h3000;
      cyc("lo_edge", 32'h3000, 1, 0, RUN);
      br_taken = 1; br_target = 32'h2ffc;
      cyc("below_lo", 32'h2ffc, 1, 1, RUN);

      idle(); exc_req = 1;
      cyc("exc3", 32'h4180, 0, 0, TRAP);
      idle(); reset = 0;
      cyc("rst_trap", 32'h3000, 1, 0, RUN);
      chk_flush("rst_trap_flush", 0);
      reset = 1;
      cyc("after_rst", 32'h3004, 1, 0, RUN);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
